psl_job_sequencer: RTL and testbench

//  PSL-side job-control initiator for CAPI AFUs, used in simulation and host-model benches.

---
 rtl/psl_job_sequencer_if.sv | 35 +++
 rtl/psl_job_sequencer.sv | 164 ++++++++++++++++
 tb/tb_psl_job_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/psl_job_sequencer_if.sv
// rtl/psl_job_sequencer_if.sv - request, job-control and response signals of the PSL job sequencer
interface psl_job_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [63:0]      req_wed;
  logic             ha_jval;
  logic [7:0]       ha_jcom;
  logic             ha_jcompar;
  logic [63:0]      ha_jea;
  logic             ha_jeapar;
  logic [7:0]       ha_croom;
  logic             ah_jrunning;
  logic             ah_jdone;
  logic [63:0]      ah_jerror;
  logic             rsp_valid;
  logic [1:0]       rsp_status;
  logic [63:0]      rsp_jerror;
  logic [CNT_W-1:0] rsp_cycles;

  // Sequencer side: drives the job bus and the response
  modport master (
    input  req_valid, req_wed, ah_jrunning, ah_jdone, ah_jerror,
    output req_ready, ha_jval, ha_jcom, ha_jcompar, ha_jea, ha_jeapar, ha_croom,
           rsp_valid, rsp_status, rsp_jerror, rsp_cycles
  );

  // Requester/AFU side
  modport slave (
    output req_valid, req_wed, ah_jrunning, ah_jdone, ah_jerror,
    input  req_ready, ha_jval, ha_jcom, ha_jcompar, ha_jea, ha_jeapar, ha_croom,
           rsp_valid, rsp_status, rsp_jerror, rsp_cycles
  );
endinterface

// File: rtl/psl_job_sequencer.sv
// rtl/psl_job_sequencer.sv - PSL-side job-control initiator: RESET, START, track AFU to completion
module psl_job_sequencer #(
  parameter logic [7:0] CROOM   = 8'd64,
  parameter int         TIMEOUT = 1000000,
  parameter int         CNT_W   = 32
) (
  input  logic                 ha_pclock,
  input  logic                 RST,
  psl_job_sequencer_if.master  bus
);

  typedef enum logic [2:0] {IDLE, RSTCMD, WRST, STCMD, WRUN, RUN, FIN} state_t;

  localparam logic [7:0]       CMD_RESET  = 8'h80;
  localparam logic [7:0]       CMD_START  = 8'h90;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_n;
  logic [63:0]      wed_q;
  logic [CNT_W-1:0] timer, run_cnt, run_cnt_inc;
  logic             timer_hit;

  logic             jval_q, jcompar_q, jeapar_q;
  logic [7:0]       jcom_q;
  logic [63:0]      jea_q;

  logic             rsp_valid_q;
  logic [1:0]       rsp_status_q;
  logic [63:0]      rsp_jerror_q;
  logic [CNT_W-1:0] rsp_cycles_q;

  // Outcome selected by the next-state logic when heading to FIN
  logic [1:0]       fin_status;
  logic             fin_eval;
  logic             fin_started;

  assign timer_hit   = (timer == TIMER_LAST);
  assign run_cnt_inc = (&run_cnt) ? run_cnt : run_cnt + CNT_ONE;

  // State register
  always_ff @(posedge ha_pclock) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and completion outcome; jdone beats protocol error beats timeout
  always_comb begin
    state_n     = state;
    fin_status  = 2'd0;
    fin_eval    = 1'b0;
    fin_started = 1'b0;
    case (state)
      IDLE:   if (bus.req_valid) state_n = RSTCMD;
      RSTCMD: state_n = WRST;
      WRST: begin
        if (bus.ah_jdone)         state_n = STCMD;
        else if (bus.ah_jrunning) begin state_n = FIN; fin_status = 2'd3; end
        else if (timer_hit)       begin state_n = FIN; fin_status = 2'd2; end
      end
      STCMD:  state_n = WRUN;
      WRUN: begin
        fin_started = 1'b1;
        if (bus.ah_jdone)         begin state_n = FIN; fin_eval = 1'b1; end
        else if (bus.ah_jrunning) state_n = RUN;
        else if (timer_hit)       begin state_n = FIN; fin_status = 2'd2; end
      end
      RUN: begin
        fin_started = 1'b1;
        if (bus.ah_jdone)          begin state_n = FIN; fin_eval = 1'b1; end
        else if (!bus.ah_jrunning) begin state_n = FIN; fin_status = 2'd3; end
        else if (timer_hit)        begin state_n = FIN; fin_status = 2'd2; end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Wait-state timer (restarted per command and on entering RUN) and saturating run-cycle counter
  always_ff @(posedge ha_pclock) begin
    if (RST) begin
      timer   <= '0;
      run_cnt <= '0;
    end else begin
      case (state)
        RSTCMD: timer <= '0;
        STCMD: begin
          timer   <= '0;
          run_cnt <= '0;
        end
        WRST:   timer <= timer + CNT_ONE;
        WRUN: begin
          timer   <= (state_n == RUN) ? '0 : timer + CNT_ONE;
          run_cnt <= run_cnt_inc;
        end
        RUN: begin
          timer   <= timer + CNT_ONE;
          run_cnt <= run_cnt_inc;
        end
        default: ;
      endcase
    end
  end

  // Latch the WED on request acceptance
  always_ff @(posedge ha_pclock) begin
    if (RST)                               wed_q <= '0;
    else if (state == IDLE && bus.req_valid) wed_q <= bus.req_wed;
  end

  // Job command bus; loaded on entry to a command state so the pulse lines up with that state
  always_ff @(posedge ha_pclock) begin
    if (RST) begin
      jval_q    <= 1'b0;
      jcom_q    <= 8'h00;
      jcompar_q <= 1'b1;
      jea_q     <= '0;
      jeapar_q  <= 1'b1;
    end else begin
      jval_q <= (state_n == RSTCMD) || (state_n == STCMD);
      if (state_n == RSTCMD) begin
        jcom_q    <= CMD_RESET;
        jcompar_q <= ~^CMD_RESET;
        jea_q     <= '0;
        jeapar_q  <= 1'b1;
      end else if (state_n == STCMD) begin
        jcom_q    <= CMD_START;
        jcompar_q <= ~^CMD_START;
        jea_q     <= wed_q;
        jeapar_q  <= ~^wed_q;
      end
    end
  end

  // Response registers; strobe is high during FIN, fields hold until the next FIN
  always_ff @(posedge ha_pclock) begin
    if (RST) begin
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= 2'd0;
      rsp_jerror_q <= '0;
      rsp_cycles_q <= '0;
    end else begin
      rsp_valid_q <= (state_n == FIN);
      if (state_n == FIN) begin
        rsp_status_q <= fin_eval ? {1'b0, |bus.ah_jerror} : fin_status;
        rsp_jerror_q <= fin_eval ? bus.ah_jerror : 64'd0;
        rsp_cycles_q <= fin_started ? run_cnt_inc : '0;
      end
    end
  end

  assign bus.req_ready  = (state == IDLE) && !RST;
  assign bus.ha_jval    = jval_q;
  assign bus.ha_jcom    = jcom_q;
  assign bus.ha_jcompar = jcompar_q;
  assign bus.ha_jea     = jea_q;
  assign bus.ha_jeapar  = jeapar_q;
  assign bus.ha_croom   = CROOM;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_jerror = rsp_jerror_q;
  assign bus.rsp_cycles = rsp_cycles_q;

endmodule

// File: tb/tb_psl_job_sequencer.sv
// tb/tb_psl_job_sequencer.sv - self-checking bench for psl_job_sequencer with AFU model and scoreboard
module tb_psl_job_sequencer;

  localparam int NEVER = 100000;

  typedef struct {
    logic [1:0]  st;
    logic [63:0] je;
    logic [31:0] cy;
    bit          chk_cy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  psl_job_sequencer_if #(.CNT_W(32)) b ();

  psl_job_sequencer #(.CROOM(8'd64), .TIMEOUT(16), .CNT_W(32)) dut (
    .ha_pclock (clk),
    .RST       (rst),
    .bus       (b)
  );

  always #5 clk = ~clk;

  // Cycle counter for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AFU model configuration (cycle offsets from the command pulse)
  int          cfg_rst_lat, cfg_run_lat, cfg_run_end, cfg_done_lat, cfg_wrst_run;
  logic [63:0] cfg_err;
  int          s_rst = -1, s_st = -1;
  int          rst_pulse_cyc = 0, n_start = 0;

  task automatic set_cfg(input int rl, input int ul, input int ue, input int dl, input int wr,
                         input logic [63:0] er);
    cfg_rst_lat = rl; cfg_run_lat = ul; cfg_run_end = ue;
    cfg_done_lat = dl; cfg_wrst_run = wr; cfg_err = er;
  endtask

  // AFU model: reacts to RESET/START pulses, drives inputs for the current cycle
  always @(negedge clk) begin
    if (rst) begin
      s_rst = -1;
      s_st  = -1;
    end else begin
      if (b.ha_jval && b.ha_jcom == 8'h80) begin
        s_rst = 0; s_st = -1; rst_pulse_cyc = cyc;
      end else if (s_rst >= 0) s_rst++;
      if (b.ha_jval && b.ha_jcom == 8'h90) begin
        s_st = 0; s_rst = -1; n_start++;
      end else if (s_st >= 0) s_st++;
    end
    b.ah_jdone    = (s_rst >= 0 && s_rst == cfg_rst_lat) || (s_st >= 0 && s_st == cfg_done_lat);
    b.ah_jrunning = (s_st >= 0 && s_st >= cfg_run_lat && s_st <= cfg_run_end) ||
                    (s_rst >= 0 && s_rst == cfg_wrst_run);
    b.ah_jerror   = (s_st >= 0 && s_st == cfg_done_lat) ? cfg_err : 64'd0;
  end

  // Monitor: scoreboard, parity, pulse width, ready-while-busy, command log
  exp_t        sb[$];
  logic [71:0] cmd_log[$];
  int          n_rsp = 0, rsp_cyc = 0, accepts = 0;
  bit          busy = 0;
  logic        prev_jval = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    chk("jcompar", b.ha_jcompar, {63'd0, ~^b.ha_jcom});
    chk("jeapar", b.ha_jeapar, {63'd0, ~^b.ha_jea});
    chk("jval_pulse", {63'd0, prev_jval & b.ha_jval}, 64'd0);
    prev_jval = b.ha_jval;
    if (b.ha_jval) cmd_log.push_back({b.ha_jcom, b.ha_jea});
    if (busy) chk("ready_busy", {63'd0, b.req_ready}, 64'd0);
    if (b.rsp_valid) begin
      n_rsp++;
      rsp_cyc = cyc;
      if (sb.size() == 0) chk("rsp_expected", 64'd0, 64'd1);
      else begin
        e = sb.pop_front();
        chk("rsp_status", {62'd0, b.rsp_status}, {62'd0, e.st});
        chk("rsp_jerror", b.rsp_jerror, e.je);
        if (e.chk_cy) chk("rsp_cycles", {32'd0, b.rsp_cycles}, {32'd0, e.cy});
      end
      busy = 0;
    end
    if (b.req_valid && b.req_ready) begin
      busy = 1;
      accepts++;
    end
    if (rst) busy = 0;
  end

  task automatic push_exp(input logic [1:0] st, input logic [63:0] je, input logic [31:0] cy,
                          input bit cc);
    exp_t e;
    e.st = st; e.je = je; e.cy = cy; e.chk_cy = cc;
    sb.push_back(e);
  endtask

  // Present one request for exactly the cycle in which it is accepted
  task automatic submit(input logic [63:0] wed);
    int n;
    n = 0;
    while (!b.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_seen", {63'd0, b.req_ready}, 64'd1);
    b.req_valid = 1'b1;
    b.req_wed   = wed;
    @(negedge clk);
    b.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n;
    n = 0;
    while (n_rsp < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrived", {63'd0, n_rsp >= target}, 64'd1);
  endtask

  initial begin
    int n0, st0;
    rst = 1'b1;
    b.req_valid = 1'b0;
    b.req_wed   = '0;
    set_cfg(3, 2, 12, 12, NEVER, 64'd0);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ready", {63'd0, b.req_ready}, 64'd0);
    chk("rst_jval", {63'd0, b.ha_jval}, 64'd0);
    chk("rst_jcom", {56'd0, b.ha_jcom}, 64'd0);
    chk("rst_jcompar", {63'd0, b.ha_jcompar}, 64'd1);
    chk("rst_jea", b.ha_jea, 64'd0);
    chk("rst_jeapar", {63'd0, b.ha_jeapar}, 64'd1);
    chk("rst_rsp_valid", {63'd0, b.rsp_valid}, 64'd0);
    chk("rst_rsp_status", {62'd0, b.rsp_status}, 64'd0);
    chk("rst_rsp_jerror", b.rsp_jerror, 64'd0);
    chk("rst_rsp_cycles", {32'd0, b.rsp_cycles}, 64'd0);
    chk("croom", {56'd0, b.ha_croom}, 64'd64);
    rst = 1'b0;
    @(negedge clk);

    // 1. Nominal job
    cmd_log.delete();
    push_exp(2'd0, 64'd0, 32'd12, 1'b1);
    submit(64'h1000);
    wait_rsp(1, 100);
    chk("nom_ncmd", cmd_log.size(), 64'd2);
    if (cmd_log.size() == 2) begin
      chk("nom_cmd0", {56'd0, cmd_log[0][71:64]}, 64'h80);
      chk("nom_ea0", cmd_log[0][63:0], 64'd0);
      chk("nom_cmd1", {56'd0, cmd_log[1][71:64]}, 64'h90);
      chk("nom_ea1", cmd_log[1][63:0], 64'h1000);
    end
    chk("ready_after_fin", {63'd0, b.req_ready}, 64'd1);

    // 2. AFU error code
    set_cfg(3, 2, 12, 12, NEVER, 64'h5);
    push_exp(2'd1, 64'h5, 32'd12, 1'b1);
    submit(64'h1000);
    wait_rsp(2, 100);

    // 3. Timeout waiting for RESET completion
    set_cfg(NEVER, NEVER, NEVER, NEVER, NEVER, 64'd0);
    cmd_log.delete();
    st0 = n_start;
    push_exp(2'd2, 64'd0, 32'd0, 1'b1);
    submit(64'h2000);
    wait_rsp(3, 100);
    chk("to_latency", rsp_cyc - rst_pulse_cyc, 64'd17);
    chk("to_no_start", n_start - st0, 64'd0);
    chk("to_ncmd", cmd_log.size(), 64'd1);

    // 4a. jrunning drops in RUN without jdone
    set_cfg(3, 2, 5, NEVER, NEVER, 64'd0);
    push_exp(2'd3, 64'd0, 32'd0, 1'b0);
    submit(64'h3000);
    wait_rsp(4, 100);

    // 4b. jrunning while waiting for RESET completion
    set_cfg(NEVER, NEVER, NEVER, NEVER, 1, 64'd0);
    push_exp(2'd3, 64'd0, 32'd0, 1'b1);
    submit(64'h4000);
    wait_rsp(5, 100);

    // 5. Reset in RUN, then a fresh job
    set_cfg(3, 2, NEVER, NEVER, NEVER, 64'd0);
    push_exp(2'd0, 64'd0, 32'd0, 1'b0);
    submit(64'h1234);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {63'd0, b.req_ready}, 64'd0);
    rst = 1'b0;
    sb.delete();
    n0 = n_rsp;
    repeat (20) @(negedge clk);
    chk("midrst_no_rsp", n_rsp - n0, 64'd0);
    set_cfg(3, 2, 12, 12, NEVER, 64'd0);
    cmd_log.delete();
    push_exp(2'd0, 64'd0, 32'd12, 1'b1);
    submit(64'hABCD);
    wait_rsp(n0 + 1, 100);
    chk("fresh_ncmd", cmd_log.size(), 64'd2);
    if (cmd_log.size() == 2) begin
      chk("fresh_cmd0", {56'd0, cmd_log[0][71:64]}, 64'h80);
      chk("fresh_ea1", cmd_log[1][63:0], 64'hABCD);
    end

    // 6. Back-to-back with req_valid held high
    n0 = n_rsp;
    st0 = accepts;
    for (int i = 0; i < 3; i++) push_exp(2'd0, 64'd0, 32'd12, 1'b1);
    b.req_wed   = 64'h5000;
    b.req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (b.req_valid && b.req_ready && accepts - st0 >= 2) break;
      @(negedge clk);
    end
    @(negedge clk);
    b.req_valid = 1'b0;
    wait_rsp(n0 + 3, 200);
    repeat (5) @(negedge clk);
    chk("b2b_accepts", accepts - st0, 64'd3);
    chk("b2b_sb_empty", sb.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
